// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target register block:
//   - state_t   : protocol FSM states of the target
//   - REG_COUNT : number of 8-bit registers in the register file
//   - PTR_W     : width of the register pointer
//   - ptr_t     : pointer type, plus a wrapping increment helper
// ---------------------------------------------------------------------------
package i2c_pkg;

   localparam int REG_COUNT = 16;
   localparam int PTR_W     = 4;

   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ADDR     = 4'd1,
      ST_ADDR_ACK = 4'd2,
      ST_PTR      = 4'd3,
      ST_WR_DATA  = 4'd4,
      ST_WR_ACK   = 4'd5,
      ST_RD_DATA  = 4'd6,
      ST_RD_ACK   = 4'd7,
      ST_IGNORE   = 4'd8
   } state_t;

   // The pointer is exactly PTR_W bits wide, so the natural overflow of the
   // addition gives the modulo-16 wrap from 0x0F back to 0x00.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA bus levels into the clk domain and turns
// them into single-cycle event flags for the target FSM.
//
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   scl_i      : raw SCL bus level
//   sda_i      : raw SDA bus level
//   scl_rise   : one-clk pulse, SCL went low -> high
//   scl_fall   : one-clk pulse, SCL went high -> low
//   start_det  : one-clk pulse, START (SDA fell while SCL high)
//   stop_det   : one-clk pulse, STOP (SDA rose while SCL high)
//   sda_bit    : synchronized SDA level aligned with the flags above
// ---------------------------------------------------------------------------
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_bit
);

   logic [1:0] scl_sync_q, scl_sync_d;
   logic [1:0] sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d;
   logic       sda_prev_q, sda_prev_d;
   logic       scl_rise_q, scl_rise_d;
   logic       scl_fall_q, scl_fall_d;
   logic       start_q,    start_d;
   logic       stop_q,     stop_d;
   logic       sda_bit_q,  sda_bit_d;
   logic       scl_s,      sda_s;

   // Two-flop synchronizers feed a one-cycle history register per line.
   // Every event is registered once more so that all flags and the sampled
   // SDA value leave this block in the same cycle.
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_i};
      sda_sync_d = {sda_sync_q[0], sda_i};
      scl_s      = scl_sync_q[1];
      sda_s      = sda_sync_q[1];
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      scl_rise_d = scl_s & ~scl_prev_q;
      scl_fall_d = ~scl_s & scl_prev_q;
      // SCL must be high in both samples so that an SDA change racing an
      // SCL edge is never mistaken for a bus condition.
      start_d    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_d     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      sda_bit_d  = sda_s;
   end

   // Idle bus is high, so the synchronizers reset to 1 to avoid a false
   // edge or condition straight after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         sda_bit_q  <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         sda_bit_q  <= sda_bit_d;
      end
   end

   assign scl_rise  = scl_rise_q;
   assign scl_fall  = scl_fall_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;
   assign sda_bit   = sda_bit_q;

endmodule

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
// I2C target exposing a 16 x 8-bit register file. A write transaction sets
// the register pointer with its first data byte and writes the following
// bytes at auto-incrementing addresses; a read transaction returns bytes
// from the current pointer, also auto-incrementing on each controller ACK.
//
// Parameters:
//   DEV_ADDR   : 7-bit bus address this target answers to
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   i2c_scl_i  : SCL bus level (asynchronous)
//   i2c_sda_i  : SDA bus level (asynchronous)
//   i2c_sda_o  : open-drain SDA drive, 1 = release, 0 = pull low
//   i2c_sda_t  : tristate enable, same value as i2c_sda_o
//   wr_strobe  : one-clk pulse per register byte written
//   wr_addr    : register index of the write, valid with wr_strobe
//   wr_data    : byte written, valid with wr_strobe
//   busy       : set by an address match, cleared by STOP/mismatch/reset
// ---------------------------------------------------------------------------
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl_i,
   input  logic       i2c_sda_i,
   output logic       i2c_sda_o,
   output logic       i2c_sda_t,
   output logic       wr_strobe,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

   state_t     state_q,     state_d;
   logic [3:0] bit_cnt_q,   bit_cnt_d;
   logic [7:0] shift_q,     shift_d;
   logic       rw_q,        rw_d;
   logic       ack_q,       ack_d;
   ptr_t       ptr_q,       ptr_d;
   logic       sda_q,       sda_d;
   logic       busy_q,      busy_d;
   logic       wr_strobe_q, wr_strobe_d;
   logic [3:0] wr_addr_q,   wr_addr_d;
   logic [7:0] wr_data_q,   wr_data_d;
   logic [7:0] regs_q [REG_COUNT];
   logic [7:0] regs_d [REG_COUNT];
   logic [7:0] full_byte;

   i2c_line_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (i2c_scl_i),
      .sda_i     (i2c_sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_bit   (sda_bit)
   );

   // The byte as it stands once the bit sampled on this SCL rise is shifted
   // in; used on the 8th rise to act on a complete byte without waiting.
   assign full_byte = {shift_q[6:0], sda_bit};

   // Protocol FSM. STOP and START override whatever the FSM is doing. Bits
   // are taken on SCL rises, SDA is only moved on SCL falls.
   //
   // In the ACK states ack_q separates the two SCL falls around the 9th bit:
   // the first fall pulls SDA low, the second one releases it and moves on.
   // In RD_ACK ack_q instead records that the controller ACKed, so the next
   // fall loads the following byte.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      ack_d       = ack_q;
      ptr_d       = ptr_q;
      sda_d       = sda_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      regs_d      = regs_q;

      if (stop_det) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 4'd0;
         ack_d     = 1'b0;
         sda_d     = 1'b1;
         busy_d    = 1'b0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
         ack_d     = 1'b0;
         sda_d     = 1'b1;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = full_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     if (full_byte[7:1] == DEV_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        rw_d    = full_byte[0];
                        ack_d   = 1'b0;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                        sda_d   = 1'b1;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_q) begin
                     sda_d = 1'b0;
                     ack_d = 1'b1;
                  end else begin
                     ack_d     = 1'b0;
                     bit_cnt_d = 4'd0;
                     if (rw_q) begin
                        // Releasing the ACK and presenting the first data
                        // bit happen on the same SCL fall.
                        state_d = ST_RD_DATA;
                        shift_d = regs_q[ptr_q];
                        sda_d   = regs_q[ptr_q][7];
                     end else begin
                        state_d = ST_PTR;
                        sda_d   = 1'b1;
                     end
                  end
               end
            end

            ST_PTR: begin
               if (scl_rise) begin
                  shift_d   = full_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     ptr_d     = full_byte[PTR_W-1:0];
                     ack_d     = 1'b0;
                     state_d   = ST_WR_ACK;
                  end
               end
            end

            ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = full_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d       = 4'd0;
                     regs_d[ptr_q]   = full_byte;
                     wr_strobe_d     = 1'b1;
                     wr_addr_d       = ptr_q;
                     wr_data_d       = full_byte;
                     ptr_d           = ptr_inc(ptr_q);
                     ack_d           = 1'b0;
                     state_d         = ST_WR_ACK;
                  end
               end
            end

            ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!ack_q) begin
                     sda_d = 1'b0;
                     ack_d = 1'b1;
                  end else begin
                     sda_d     = 1'b1;
                     ack_d     = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = ST_WR_DATA;
                  end
               end
            end

            ST_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_d   = 1'b1;
                     ack_d   = 1'b0;
                     state_d = ST_RD_ACK;
                  end else begin
                     // Rotate so bit 6 becomes the next MSB on the wire.
                     shift_d = {shift_q[6:0], shift_q[7]};
                     sda_d   = shift_q[6];
                  end
               end
            end

            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_bit) begin
                     ptr_d = ptr_inc(ptr_q);
                     ack_d = 1'b1;
                  end else begin
                     sda_d   = 1'b1;
                     state_d = ST_IGNORE;
                  end
               end else if (scl_fall && ack_q) begin
                  ack_d     = 1'b0;
                  bit_cnt_d = 4'd0;
                  shift_d   = regs_q[ptr_q];
                  sda_d     = regs_q[ptr_q][7];
                  state_d   = ST_RD_DATA;
               end
            end

            // IDLE and IGNORE only leave on START/STOP, handled above.
            default: begin
            end
         endcase
      end
   end

   // State, datapath and register file. The asynchronous reset releases SDA
   // immediately, even in the middle of an ACK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         rw_q        <= 1'b0;
         ack_q       <= 1'b0;
         ptr_q       <= '0;
         sda_q       <= 1'b1;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 4'd0;
         wr_data_q   <= 8'h00;
         regs_q      <= '{default: 8'h00};
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         ack_q       <= ack_d;
         ptr_q       <= ptr_d;
         sda_q       <= sda_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         regs_q      <= regs_d;
      end
   end

   assign i2c_sda_o = sda_q;
   assign i2c_sda_t = sda_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
// Bench acting as I2C controller on a wired-AND SDA line. A byte-level
// model of the register target predicts ACK bits, read data and register
// writes; a per-cycle process matches every wr_strobe against the queue of
// writes the model expects.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_target_regs;

   localparam int HALF_CLKS = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ctl_scl = 1'b1;
   logic       ctl_sda = 1'b1;
   logic       resp_sda_o;
   logic       sda_t;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   wire        bus_sda = ctl_sda & resp_sda_o;

   int checks = 0;
   int failures = 0;
   int strobe_count = 0;

   // Byte-level model of the target
   logic [7:0]  model_regs [16];
   int          model_ptr;
   bit          model_addr_phase;
   bit          model_addressed;
   bit          model_rw;
   bit          model_ptr_pending;
   logic [11:0] exp_writes [$];
   logic [11:0] exp_entry;

   i2c_target_regs #(.DEV_ADDR(7'h50)) dut (
      .clk       (clk),
      .rst       (rst),
      .i2c_scl_i (ctl_scl),
      .i2c_sda_i (bus_sda),
      .i2c_sda_o (resp_sda_o),
      .i2c_sda_t (sda_t),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic model_reset();
      foreach (model_regs[i]) model_regs[i] = 8'h00;
      model_ptr         = 0;
      model_addr_phase  = 1'b0;
      model_addressed   = 1'b0;
      model_rw          = 1'b0;
      model_ptr_pending = 1'b0;
      exp_writes.delete();
   endtask

   // Every register write the DUT reports must be the next one predicted.
   always @(negedge clk) begin
      if (!rst && wr_strobe) begin
         strobe_count++;
         if (exp_writes.size() == 0) begin
            checkOutput("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
         end else begin
            exp_entry = exp_writes.pop_front();
            checkOutput("wr_addr", 32'(wr_addr), 32'(exp_entry[11:8]));
            checkOutput("wr_data", 32'(wr_data), 32'(exp_entry[7:0]));
         end
      end
   end

   initial begin
      repeat (100000) @(posedge clk);
      $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic half();
      repeat (HALF_CLKS) @(negedge clk);
   endtask

   // One SCL clock: SDA set while SCL is low, bus sampled mid-high.
   task automatic bit_cycle(input logic drive, output logic sampled);
      ctl_sda = drive;
      half();
      ctl_scl = 1'b1;
      half();
      sampled = bus_sda;
      half();
      ctl_scl = 1'b0;
      half();
   endtask

   // Works both from an idle bus and as a repeated START with SCL low.
   task automatic i2c_start();
      model_addr_phase = 1'b1;
      ctl_sda = 1'b1;
      half();
      ctl_scl = 1'b1;
      half();
      ctl_sda = 1'b0;
      half();
      ctl_scl = 1'b0;
      half();
   endtask

   task automatic i2c_stop();
      model_addr_phase = 1'b0;
      model_addressed  = 1'b0;
      ctl_sda = 1'b0;
      half();
      ctl_scl = 1'b1;
      half();
      ctl_sda = 1'b1;
      half();
      half();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) bit_cycle(b[i], dummy);
      bit_cycle(1'b1, ack);
   endtask

   // Sends one controller byte, updates the model and checks the ACK bit.
   task automatic applyStimulus(input logic [7:0] b, input string name);
      logic exp_ack;
      logic ack;
      if (model_addr_phase) begin
         model_addr_phase = 1'b0;
         if (b[7:1] == 7'h50) begin
            model_addressed   = 1'b1;
            model_rw          = b[0];
            model_ptr_pending = !b[0];
            exp_ack           = 1'b0;
         end else begin
            model_addressed = 1'b0;
            exp_ack         = 1'b1;
         end
      end else if (model_addressed && !model_rw) begin
         exp_ack = 1'b0;
         if (model_ptr_pending) begin
            model_ptr         = int'(b) % 16;
            model_ptr_pending = 1'b0;
         end else begin
            exp_writes.push_back({4'(model_ptr), b});
            model_regs[4'(model_ptr)] = b;
            model_ptr = (model_ptr + 1) % 16;
         end
      end else begin
         exp_ack = 1'b1;
      end
      send_byte(b, ack);
      checkOutput({name, "_ack"}, 32'(ack), 32'(exp_ack));
   endtask

   // Reads one byte, checks it against the model and a literal value.
   task automatic read_byte(input logic ack_bit, input string name, input logic [7:0] literal);
      logic [7:0] data;
      logic [7:0] expected;
      logic       s;
      expected = model_regs[4'(model_ptr)];
      data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bit_cycle(1'b1, s);
         data = {data[6:0], s};
      end
      bit_cycle(ack_bit, s);
      checkOutput(name, 32'(data), 32'(expected));
      checkOutput({name, "_lit"}, 32'(data), 32'(literal));
      if (!ack_bit) model_ptr = (model_ptr + 1) % 16;
   endtask

   initial begin
      logic dummy;
      logic [7:0] ptr_byte;
      model_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_sda_o", 32'(resp_sda_o), 32'd1);
      checkOutput("rst_sda_t", 32'(sda_t), 32'd1);
      checkOutput("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] write 0x03 <- A5 5A");
      i2c_start();
      applyStimulus(8'hA0, "w1_addr");
      checkOutput("w1_busy", 32'(busy), 32'd1);
      applyStimulus(8'h03, "w1_ptr");
      applyStimulus(8'hA5, "w1_d0");
      applyStimulus(8'h5A, "w1_d1");
      i2c_stop();
      checkOutput("w1_busy_after_stop", 32'(busy), 32'd0);
      checkOutput("w1_strobes", 32'(strobe_count), 32'd2);

      $display("[TB] read back from 0x03 with repeated START");
      i2c_start();
      applyStimulus(8'hA0, "r1_waddr");
      applyStimulus(8'h03, "r1_ptr");
      i2c_start();
      applyStimulus(8'hA1, "r1_raddr");
      checkOutput("r1_busy", 32'(busy), 32'd1);
      read_byte(1'b0, "r1_d0", 8'hA5);
      read_byte(1'b1, "r1_d1", 8'h5A);
      checkOutput("r1_sda_released", 32'(resp_sda_o), 32'd1);
      checkOutput("r1_sda_t_released", 32'(sda_t), 32'd1);
      i2c_stop();

      $display("[TB] wrong address 0x51");
      i2c_start();
      applyStimulus(8'hA2, "bad_addr");
      checkOutput("bad_busy", 32'(busy), 32'd0);
      i2c_stop();
      checkOutput("bad_strobes", 32'(strobe_count), 32'd2);

      $display("[TB] pointer wrap 0x0F -> 0x00");
      i2c_start();
      applyStimulus(8'hA0, "wrap_addr");
      applyStimulus(8'h0F, "wrap_ptr");
      applyStimulus(8'h11, "wrap_d0");
      applyStimulus(8'h22, "wrap_d1");
      i2c_stop();
      checkOutput("wrap_strobes", 32'(strobe_count), 32'd4);
      i2c_start();
      applyStimulus(8'hA0, "wrap_rwaddr");
      applyStimulus(8'h0F, "wrap_rptr");
      i2c_start();
      applyStimulus(8'hA1, "wrap_raddr");
      read_byte(1'b0, "wrap_r15", 8'h11);
      read_byte(1'b1, "wrap_r0", 8'h22);
      i2c_stop();

      $display("[TB] STOP in the middle of a data byte");
      i2c_start();
      applyStimulus(8'hA0, "mid_addr");
      applyStimulus(8'h04, "mid_ptr");
      bit_cycle(1'b1, dummy);
      bit_cycle(1'b1, dummy);
      bit_cycle(1'b0, dummy);
      bit_cycle(1'b0, dummy);
      i2c_stop();
      checkOutput("mid_busy", 32'(busy), 32'd0);
      checkOutput("mid_strobes", 32'(strobe_count), 32'd4);
      i2c_start();
      applyStimulus(8'hA1, "mid_raddr");
      read_byte(1'b0, "mid_r4", 8'h5A);
      read_byte(1'b1, "mid_r5", 8'h00);
      i2c_stop();

      $display("[TB] reset during the pointer ACK");
      i2c_start();
      applyStimulus(8'hA0, "rst_addr");
      ptr_byte = 8'h07;
      for (int i = 7; i >= 0; i--) bit_cycle(ptr_byte[i], dummy);
      ctl_sda = 1'b1;
      half();
      ctl_scl = 1'b1;
      half();
      checkOutput("rst_ack_driven", 32'(bus_sda), 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_sda_o", 32'(resp_sda_o), 32'd1);
      checkOutput("rst_mid_sda_t", 32'(sda_t), 32'd1);
      model_reset();
      repeat (3) @(negedge clk);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_wr_data", 32'(wr_data), 32'd0);
      rst = 1'b0;
      half();
      ctl_scl = 1'b0;
      half();
      i2c_stop();
      i2c_start();
      applyStimulus(8'hA0, "post_addr");
      applyStimulus(8'h02, "post_ptr");
      applyStimulus(8'h77, "post_d0");
      i2c_stop();
      checkOutput("post_strobes", 32'(strobe_count), 32'd5);
      i2c_start();
      applyStimulus(8'hA0, "post_rwaddr");
      applyStimulus(8'h02, "post_rptr");
      i2c_start();
      applyStimulus(8'hA1, "post_raddr");
      read_byte(1'b0, "post_r2", 8'h77);
      read_byte(1'b1, "post_r3", 8'h00);
      i2c_stop();

      repeat (4) @(negedge clk);
      checkOutput("pending_writes", 32'(exp_writes.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50, is the 7-bit I2C target address this block responds to.
REQ-002 clk  input  1  single system clock; all logic in this domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i2c_scl_i  input  1  bus SCL level (wired-AND); asynchronous to clk.
REQ-005 i2c_sda_i  input  1  bus SDA level (wired-AND); asynchronous to clk.
REQ-006 i2c_sda_o  output  1  open-drain SDA drive; 1 = release, 0 = pull low; connects to the bench-side resp_sda_o net.
REQ-007 i2c_sda_t  output  1  tristate enable; equals i2c_sda_o (1 = high-Z).
REQ-008 wr_strobe  output  1  one-clk pulse per data byte written to the register file.
REQ-009 wr_addr  output  4  register index written; valid while wr_strobe = 1.
REQ-010 wr_data  output  8  byte written; valid while wr_strobe = 1.
REQ-011 busy  output  1  1 from an address-matched START until the next STOP, mismatch, or reset.

Function
REQ-012 SCL and SDA each pass through a 2-flop synchronizer; edges and conditions are detected on the synchronized signals.
REQ-013 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are flagged one clk after detection.
REQ-014 Bits are sampled on SCL rising edges; i2c_sda_o changes only on SCL falling edges, except on STOP or reset.
REQ-015 States: IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 START from any state -> ADDR, clear the bit counter, release SDA (repeated START supported).
REQ-017 STOP from any state -> IDLE, release SDA, busy = 0.
REQ-018 ADDR: shift 8 bits MSB first; if bits[7:1] == DEV_ADDR -> ADDR_ACK and record R/W = bit 0; otherwise -> IDLE with SDA released (NACK).
REQ-019 ACK drive: SDA low from the SCL falling edge after the 8th bit until the SCL falling edge after the 9th bit.
REQ-020 Write (R/W = 0): the first byte after the address loads the 4-bit pointer (bits [7:4] ignored) and is ACKed; each later byte is written to reg[ptr], pulses wr_strobe, is ACKed, and then ptr increments.
REQ-021 Read (R/W = 1): reg[ptr] loads on the ADDR_ACK-ending SCL fall; bits are shifted MSB first on SCL falls; SDA is released for the 9th bit, and the controller ACK/NACK is sampled on the 9th SCL rise.
REQ-022 Read ACK: ptr increments and the next byte loads; read NACK -> IGNORE, with SDA released until START or STOP.
REQ-023 Pointer arithmetic is 4-bit modulo 16; ptr 0x0F wraps to 0x00 with no error.
REQ-024 Register file: 16 x 8 bits; the pointer persists across transactions until overwritten or reset.
REQ-025 In a read, SDA driven low by the target while the sampled bus reads high is not checked (no arbitration; the target never loses).

Reset
REQ-026 rst asserted: state = IDLE; i2c_sda_o = 1; i2c_sda_t = 1; wr_strobe = 0; wr_addr = 0; wr_data = 0; busy = 0; ptr = 0; all registers = 8'h00; synchronizers = 1.
REQ-027 Reset mid-transfer releases SDA within the same cycle (asynchronous); after deassertion the block waits in IDLE for a new START.

Structure
REQ-028 Shared package i2c_pkg holds the state enum, the register-count constant (16), and the pointer width (4).
REQ-029 One sub-module, i2c_line_sync, holds the synchronizers, the SCL rise/fall detectors, and START/STOP detection; the FSM, shifter and register file sit in i2c_target_regs.

Verification
REQ-030 Write 0x50+W, ptr 0x03, data 0xA5, 0x5A, STOP -> all 4 bytes ACKed; wr_strobe pulses twice (3/A5, 4/5A); reg[3] = A5, reg[4] = 5A.
REQ-031 After REQ-030: write 0x50+W, ptr 0x03, repeated START, 0x50+R, read 2 bytes (ACK, then NACK) -> target returns 0xA5, 0x5A and releases SDA after the NACK.
REQ-032 Address 0x51+W -> 9th bit NACK (SDA high); no wr_strobe; busy stays 0; the next transaction to 0x50 succeeds.
REQ-033 Write ptr 0x0F, data 0x11, 0x22 -> reg[15] = 11, reg[0] = 22 (wrap-around).
REQ-034 Assert rst during the ACK bit of the ptr byte -> i2c_sda_o = 1 immediately, all registers 0; a following full write succeeds.
REQ-035 STOP issued mid-byte (after 4 data bits) -> no wr_strobe; the FSM returns to IDLE; reg contents unchanged.
